// File: rtl/csa_sub_41bit.sv
// Chunk-serial subtractor that recovers the second addend of a carry-select add.
// Processes one 4-bit chunk per clock, LSB first, with a registered ripple borrow.
module csa_sub_41bit #(
  parameter int WIDTH      = 41,
  parameter int BIT_REMAIN = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_cout,
  input  logic [WIDTH-1:0] i_add_term1,
  output logic [WIDTH-1:0] o_add_term2,
  output logic             o_error,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int NCHUNK = WIDTH / 4 + ((BIT_REMAIN > 0) ? 1 : 0);
  localparam int PADW   = NCHUNK * 4;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int IW     = $clog2(PADW);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           r_state;
  logic [PADW-1:0]  r_sum;
  logic [PADW-1:0]  r_t1;
  logic             r_cout;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_err;
  logic             r_ready;
  logic             r_valid;

  logic [IW-1:0]    w_base;
  logic [3:0]       w_a;
  logic [3:0]       w_b;
  logic [4:0]       w_diff;
  logic             w_bout;

  // Operands are zero-padded to whole chunks, so bit 4 of the
  // difference is the borrow even for the short final chunk.
  assign w_base = IW'({r_cnt, 2'b00});
  assign w_a    = r_sum[w_base +: 4];
  assign w_b    = r_t1[w_base +: 4];
  assign w_diff = {1'b0, w_a} - {1'b0, w_b} - {4'b0000, r_borrow};
  assign w_bout = w_diff[4];

  assign o_ready     = r_ready;
  assign o_valid     = r_valid;
  assign o_add_term2 = r_res;
  assign o_error     = r_err;

  // Control FSM plus the chunk datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_sum    <= '0;
      r_t1     <= '0;
      r_cout   <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_res    <= '0;
      r_err    <= 1'b0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_sum    <= PADW'(i_sum);
            r_t1     <= PADW'(i_add_term1);
            r_cout   <= i_cout;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 0; i < 4; i++) begin
            if (int'(w_base) + i < WIDTH) begin
              r_res[w_base + IW'(i)] <= w_diff[i];
            end
          end
          r_borrow <= w_bout;
          if (r_cnt == LAST) begin
            r_err   <= r_cout ^ w_bout;
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
